// File: rtl/shufflenetv2_mac_pkg.sv
// rtl/shufflenetv2_mac_pkg.sv - shared types, limits and saturation bounds for the MAC pipe
package shufflenetv2_mac_pkg;

    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 6;

    // Per-beat sideband that travels alongside the product through the pipe
    typedef struct packed {
        logic sgn;
        logic first;
        logic last;
        logic valid;
    } beat_sb_t;

    // Upper clamp bound for a w-bit accumulator, right-aligned in 64 bits
    function automatic logic [63:0] sat_hi(input logic sgn, input int unsigned w);
        if (sgn) begin
            return (64'd1 << (w - 1)) - 64'd1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    // Lower clamp bound for a w-bit accumulator, sign-extended to 64 bits
    function automatic logic [63:0] sat_lo(input logic sgn, input int unsigned w);
        if (sgn) begin
            return ~((64'd1 << (w - 1)) - 64'd1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/shufflenetv2_mac_mul.sv
// rtl/shufflenetv2_mac_mul.sv - operand extension and retimable product pipe with sideband
module shufflenetv2_mac_mul
    import shufflenetv2_mac_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int DEPTH = 2
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ce,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  beat_sb_t           sb_in,
    output logic [A_W+B_W-1:0] prod,
    output beat_sb_t           sb_out
);

    localparam int PW = A_W + B_W;

    // Only the low PW bits of the product matter, so extending both operands
    // to PW bits and multiplying modulo 2^PW covers signed and unsigned alike.
    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    logic [PW-1:0] prod_c;

    assign a_x    = {{B_W{sb_in.sgn & a[A_W-1]}}, a};
    assign b_x    = {{A_W{sb_in.sgn & b[B_W-1]}}, b};
    assign prod_c = a_x * b_x;

    logic [PW-1:0] prod_q [DEPTH];
    beat_sb_t      sb_q   [DEPTH];

    // Product registers carry no reset so synthesis can retime them into the DSP
    always_ff @(posedge ap_clk) begin
        if (ce) begin
            prod_q[0] <= prod_c;
            for (int i = 1; i < DEPTH; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Sideband shift register; reset drops every in-flight beat
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (ce) begin
            sb_q[0] <= sb_in;
            for (int i = 1; i < DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign prod   = prod_q[DEPTH-1];
    assign sb_out = sb_q[DEPTH-1];

endmodule

// File: rtl/shufflenetv2_mac_pipe.sv
// rtl/shufflenetv2_mac_pipe.sv - pipelined grouped MAC with handshake; SHUFFLENETV2_MAC_SAT_EN adds saturation and out_sat
module shufflenetv2_mac_pipe
    import shufflenetv2_mac_pkg::*;
#(
    parameter int A_W       = 8,
    parameter int B_W       = 8,
    parameter int ACC_W     = 24,
    parameter int NUM_STAGE = 3,
    parameter int CNT_W     = 10
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt
`ifdef SHUFFLENETV2_MAC_SAT_EN
    ,
    output logic             out_sat
`endif
);

    localparam int PW = A_W + B_W;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("NUM_STAGE out of range");
    end
    if (ACC_W < PW) begin : g_bad_acc
        $error("ACC_W narrower than product");
    end

    logic          ce;
    beat_sb_t      sb_in;
    beat_sb_t      sb_s;
    logic [PW-1:0] prod_s;

    // One global enable: the pipe advances whenever the output slot is free or being drained
    assign ce       = !out_valid | out_ready;
    assign in_ready = ce;
    assign sb_in    = '{sgn: in_signed, first: in_first, last: in_last, valid: in_valid & ce};

    shufflenetv2_mac_mul #(
        .A_W   (A_W),
        .B_W   (B_W),
        .DEPTH (NUM_STAGE - 1)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .a        (in_a),
        .b        (in_b),
        .sb_in    (sb_in),
        .prod     (prod_s),
        .sb_out   (sb_s)
    );

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             closed_q;
    logic             fresh;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    assign ext   = sb_s.sgn ? ACC_W'($signed(prod_s)) : ACC_W'(prod_s);
    assign fresh = sb_s.first | closed_q;

`ifdef SHUFFLENETV2_MAC_SAT_EN
    logic [ACC_W:0] sum_x;
    logic [63:0]    hi64;
    logic [63:0]    lo64;
    logic           sat_q;

    // Widened add; overflow clamps to the bound of the current beat's mode
    always_comb begin
        sum_x = '0;
        ovf   = 1'b0;
        sum   = '0;
        hi64  = sat_hi(sb_s.sgn, ACC_W);
        lo64  = sat_lo(sb_s.sgn, ACC_W);
        if (sb_s.sgn) begin
            sum_x = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
            ovf   = sum_x[ACC_W] ^ sum_x[ACC_W-1];
        end else begin
            sum_x = {1'b0, acc_q} + {1'b0, ext};
            ovf   = sum_x[ACC_W];
        end
        if (!ovf) begin
            sum = sum_x[ACC_W-1:0];
        end else if (sb_s.sgn & sum_x[ACC_W]) begin
            sum = lo64[ACC_W-1:0];
        end else begin
            sum = hi64[ACC_W-1:0];
        end
    end

    // Sticky clamp flag, restarted with each group
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sat_q <= 1'b0;
        end else if (ce && sb_s.valid) begin
            sat_q <= fresh ? 1'b0 : (sat_q | ovf);
        end
    end

    assign out_sat = sat_q;
`else
    // Plain modular accumulate
    always_comb begin
        ovf = 1'b0;
        sum = acc_q + ext;
    end
`endif

    // Accumulate stage: load or add, count beats, raise out_valid on the closing beat
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            closed_q  <= 1'b1;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (sb_s.valid) begin
                if (fresh) begin
                    acc_q <= ext;
                    cnt_q <= CNT_W'(1);
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                closed_q  <= sb_s.last;
                out_valid <= sb_s.last;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_acc = acc_q;
    assign out_cnt = cnt_q;

endmodule

// File: tb/tb_shufflenetv2_mac_pipe.sv
// tb/tb_shufflenetv2_mac_pipe.sv - scoreboard bench for the MAC pipe (ACC_W=16)
module tb_shufflenetv2_mac_pipe;

    localparam int A_W   = 8;
    localparam int B_W   = 8;
    localparam int ACC_W = 16;
    localparam int NS    = 3;
    localparam int CNT_W = 10;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_signed;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
`ifdef SHUFFLENETV2_MAC_SAT_EN
    logic             out_sat;
`endif

    typedef struct {
        int acc;
        int cnt;
        int cyc;
        bit sat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    shufflenetv2_mac_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .ACC_W     (ACC_W),
        .NUM_STAGE (NS),
        .CNT_W     (CNT_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
`ifdef SHUFFLENETV2_MAC_SAT_EN
        .out_sat   (out_sat),
`endif
        .out_cnt   (out_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, push expectation on a closing beat
    task automatic send(input int a, input int b, input bit s, input bit f, input bit l,
                        input int eacc, input int ecnt, input bit esat, input bit timed);
        exp_t e;
        int   n;
        in_a      = A_W'(a);
        in_b      = B_W'(b);
        in_signed = s;
        in_first  = f;
        in_last   = l;
        in_valid  = 1'b1;
        n = 0;
        forever begin
            @(negedge ap_clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        if (l) begin
            e.acc = eacc;
            e.cnt = ecnt;
            e.sat = esat;
            e.cyc = timed ? cyc + NS - 1 : 0;
            sbq.push_back(e);
        end
    endtask

    // Monitor: every delivered result is matched against the head of the scoreboard
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", int'(out_acc), -1);
            end else begin
                e = sbq.pop_front();
                chk("out_acc", int'(out_acc), e.acc);
                chk("out_cnt", int'(out_cnt), e.cnt);
                if (e.cyc != 0) chk("latency", cyc, e.cyc);
`ifdef SHUFFLENETV2_MAC_SAT_EN
                chk("out_sat", int'(out_sat), int'(e.sat));
`endif
            end
        end
    end

    initial begin
        int n;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_acc", int'(out_acc), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge ap_clk);
        #1;

        // Unsigned 3-beat group: 51000 + 1 + 100
        send(200, 255, 0, 1, 0, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0, 0, 0, 0);
        send(10, 10, 0, 0, 1, 51101, 3, 0, 1);
        repeat (NS + 2) @(posedge ap_clk);
        #1;

        // Signed single beat: -128 * 127 = -16256 -> 0xC080 in 16 bits
        send(8'h80, 8'h7f, 1, 1, 1, 16'hC080, 1, 0, 1);
        repeat (NS + 2) @(posedge ap_clk);
        #1;

        // Backpressure: two results, held until out_ready rises
        out_ready = 1'b0;
        send(2, 3, 0, 1, 1, 6, 1, 0, 0);
        send(4, 5, 0, 1, 1, 20, 1, 0, 0);
        repeat (NS + 2) @(negedge ap_clk);
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_acc", int'(out_acc), 6);
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
        repeat (NS + 3) @(posedge ap_clk);
        #1;

        // Reset mid-group: partial sum and in-flight beats vanish
        send(1, 2, 0, 1, 0, 0, 0, 0, 0);
        send(3, 4, 0, 0, 0, 0, 0, 0, 0);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        repeat (NS + 2) @(posedge ap_clk);
        #1;
        send(7, 7, 0, 1, 1, 49, 1, 0, 1);
        repeat (NS + 2) @(posedge ap_clk);
        #1;

        // Two 255*255 beats: 130050 wraps to 64514, or clamps to 65535
`ifdef SHUFFLENETV2_MAC_SAT_EN
        send(255, 255, 0, 1, 0, 0, 0, 0, 0);
        send(255, 255, 0, 0, 1, 65535, 2, 1, 0);
`else
        send(255, 255, 0, 1, 0, 0, 0, 0, 0);
        send(255, 255, 0, 0, 1, 64514, 2, 0, 0);
`endif

        // Mid-group restart: first beat dropped, 4 + 9
        send(1, 1, 0, 1, 0, 0, 0, 0, 0);
        send(2, 2, 0, 1, 0, 0, 0, 0, 0);
        send(3, 3, 0, 0, 1, 13, 2, 0, 1);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        chk("drain_pending", sbq.size(), 0);
        repeat (10) @(posedge ap_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
